// File: rtl/pll_ctrl_pkg.sv
// Shared types and defaults for the PLL controller.
//   state_e    : controller sequencing states
//   pll_div_t  : OD (output divider) code driven to the PLL wrapper
//   max2       : elaboration-time helper for sizing the shared counter
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    SETTLE_ON,
    RUN,
    SETTLE_OFF,
    FAIL
  } state_e;

  typedef logic [1:0] pll_div_t;

  localparam pll_div_t PLL_DIV_RESET = 2'b11;

  function automatic int unsigned max2(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_ctrl_if.sv
// Divider-change request handshake between a requester and pll_ctrl.
//   div_req        : requested OD code
//   div_req_valid  : request pending; held by the requester until ready
//   div_req_ready  : controller can take the request this cycle
interface pll_ctrl_if;
  import pll_ctrl_pkg::*;

  pll_div_t div_req;
  logic     div_req_valid;
  logic     div_req_ready;

  modport master (output div_req, div_req_valid, input  div_req_ready);
  modport slave  (input  div_req, div_req_valid, output div_req_ready);

endinterface

// File: rtl/pll_ctrl_sync.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk_i  : destination clock
//   rstn_i : asynchronous active-low reset, output clears to 0
//   d_i    : asynchronous input
//   q_o    : synchronized output, two cycles of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sync_q <= '0;
    else         sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/pll_ctrl.sv
// PLL sequencing controller on the reference clock. Drives the PLL wrapper's
// reset, divider and bypass, qualifies its lock output, and hands the core
// clock over from bypass to the PLL only after lock has been stable.
//   clk_i, rstn_i : reference clock, asynchronous active-low reset
//   req_if        : divider change request handshake (slave side)
//   pll_locked_i  : PLL lock detect, asynchronous to clk_i
//   pll_rstn_o    : PLL reset, active-low
//   pll_div_o     : OD code to the PLL
//   pll_bps_o     : PLL bypass
//   pll_ready_o   : PLL output valid and in use
//   lock_lost_o   : one-cycle pulse when lock drops in RUN
//   fail_o        : lock retries exhausted
module pll_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES          = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned BPS_SETTLE_CYCLES   = 4,
  parameter pll_div_t    DIV_RESET           = PLL_DIV_RESET
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  pll_ctrl_if.slave  req_if,
  input  logic       pll_locked_i,
  output logic       pll_rstn_o,
  output pll_div_t   pll_div_o,
  output logic       pll_bps_o,
  output logic       pll_ready_o,
  output logic       lock_lost_o,
  output logic       fail_o
);

  localparam int unsigned CNT_MAX = max2(max2(RST_CYCLES, LOCK_STABLE_CYCLES),
                                         max2(LOCK_TIMEOUT_CYCLES, BPS_SETTLE_CYCLES));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned RTY_W   = $clog2(MAX_RETRIES + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             rstn_q, rstn_d;
  pll_div_t         div_q, div_d;
  logic             bps_q, bps_d;
  logic             rdy_q, rdy_d;
  logic             ll_q, ll_d;
  logic             fail_q, fail_d;

  logic lock_s;
  logic req_ready;
  logic accept;

  sync_2ff u_lock_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (pll_locked_i),
    .q_o    (lock_s)
  );

  // In RUN, ready follows lock_s so a lock drop always wins over a request
  // arriving in the same cycle; the request simply stays pending.
  assign req_ready            = (state_q == RUN && lock_s) || (state_q == FAIL);
  assign accept               = req_if.div_req_valid && req_ready;
  assign req_if.div_req_ready = req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    rstn_d  = rstn_q;
    div_d   = div_q;
    bps_d   = bps_q;
    rdy_d   = rdy_q;
    ll_d    = 1'b0;
    fail_d  = fail_q;

    unique case (state_q)
      PLL_RST: begin
        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
          rstn_d  = 1'b1;
          state_d = WAIT_LOCK;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_d = retry_q + 1'b1;
          rstn_d  = 1'b0;
          if (retry_q == RTY_W'(MAX_RETRIES - 1)) begin
            fail_d  = 1'b1;
            state_d = FAIL;
          end else begin
            state_d = PLL_RST;
          end
        end
      end
      STABLE: begin
        // A glitch only restarts qualification; it is never reported as a loss.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          bps_d   = 1'b0;
          state_d = SETTLE_ON;
        end
      end
      SETTLE_ON: begin
        if (cnt_q == CNT_W'(BPS_SETTLE_CYCLES - 1)) begin
          rdy_d   = 1'b1;
          retry_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!lock_s) begin
          ll_d    = 1'b1;
          bps_d   = 1'b1;
          rdy_d   = 1'b0;
          rstn_d  = 1'b0;
          state_d = PLL_RST;
        end else if (accept) begin
          // Bypass and divider switch on the same edge: the PLL output is
          // dropped from the mux here and is not used again until the settle
          // window and a full reset/relock have passed.
          div_d   = req_if.div_req;
          bps_d   = 1'b1;
          rdy_d   = 1'b0;
          state_d = SETTLE_OFF;
        end
      end
      SETTLE_OFF: begin
        if (cnt_q == CNT_W'(BPS_SETTLE_CYCLES - 1)) begin
          rstn_d  = 1'b0;
          state_d = PLL_RST;
        end
      end
      FAIL: begin
        rstn_d = 1'b0;
        bps_d  = 1'b1;
        if (accept) begin
          div_d   = req_if.div_req;
          fail_d  = 1'b0;
          retry_d = '0;
          state_d = PLL_RST;
        end
      end
      default: begin
        rstn_d  = 1'b0;
        bps_d   = 1'b1;
        rdy_d   = 1'b0;
        state_d = PLL_RST;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      rstn_q  <= 1'b0;
      div_q   <= DIV_RESET;
      bps_q   <= 1'b1;
      rdy_q   <= 1'b0;
      ll_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      rstn_q  <= rstn_d;
      div_q   <= div_d;
      bps_q   <= bps_d;
      rdy_q   <= rdy_d;
      ll_q    <= ll_d;
      fail_q  <= fail_d;
    end
  end

  assign pll_rstn_o  = rstn_q;
  assign pll_div_o   = div_q;
  assign pll_bps_o   = bps_q;
  assign pll_ready_o = rdy_q;
  assign lock_lost_o = ll_q;
  assign fail_o      = fail_q;

endmodule
